// File: rtl/dmem_responder.sv
// Data-memory responder: single outstanding request, fixed wait states, then a
// byte/half/word access on a word-organised RAM with a registered one-cycle reply.
module dmem_responder #(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [1:0]  size,
   input  logic        uns,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        ready,
   output logic        err,
   output logic [31:0] rdata
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                state;
   logic [3:0]            cnt;
   logic                  l_we;
   logic                  l_uns;
   logic [1:0]            l_size;
   logic [31:0]           l_addr;
   logic [31:0]           l_wdata;

   logic [31:0]           mem [2**ADDR_WIDTH];
   logic [ADDR_WIDTH-1:0] widx;
   logic                  access;
   logic                  bad;
   logic [3:0]            be;
   logic [31:0]           wlanes;
   logic [31:0]           rword;
   logic [31:0]           rshift;
   logic [31:0]           ldata;

   assign widx   = l_addr[ADDR_WIDTH+1:2];
   assign access = (state == WAIT) && (cnt == '0);

   always_comb begin
      bad    = 1'b0;
      be     = '0;
      wlanes = l_wdata;
      ldata  = '0;
      rword  = mem[widx];
      rshift = rword >> {l_addr[1:0], 3'b000};

      if ((l_addr >> (ADDR_WIDTH + 2)) != '0)
         bad = 1'b1;

      // store data is replicated across lanes so the byte enables alone pick the target
      case (l_size)
         2'b00: begin
            be     = 4'b0001 << l_addr[1:0];
            wlanes = {4{l_wdata[7:0]}};
            ldata  = l_uns ? {24'h0, rshift[7:0]} : {{24{rshift[7]}}, rshift[7:0]};
         end
         2'b01: begin
            if (l_addr[0])
               bad = 1'b1;
            be     = l_addr[1] ? 4'b1100 : 4'b0011;
            wlanes = {2{l_wdata[15:0]}};
            ldata  = l_uns ? {16'h0, rshift[15:0]} : {{16{rshift[15]}}, rshift[15:0]};
         end
         2'b10: begin
            if (l_addr[1:0] != 2'b00)
               bad = 1'b1;
            be     = 4'b1111;
            ldata  = rword;
         end
         default: bad = 1'b1;
      endcase
   end

   // RAM is not reset; a reset on the access edge simply blocks the write
   always_ff @(posedge clk) begin
      if (reset && access && l_we && !bad) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (be[i])
               mem[widx][8*i +: 8] <= wlanes[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= '0;
         busy    <= 1'b0;
         ready   <= 1'b0;
         err     <= 1'b0;
         rdata   <= '0;
         l_we    <= 1'b0;
         l_uns   <= 1'b0;
         l_size  <= '0;
         l_addr  <= '0;
         l_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               ready <= 1'b0;
               if (req) begin
                  l_we    <= we;
                  l_uns   <= uns;
                  l_size  <= size;
                  l_addr  <= addr;
                  l_wdata <= wdata;
                  cnt     <= 4'(WAIT_CYCLES);
                  busy    <= 1'b1;
                  state   <= WAIT;
               end
            end
            WAIT: begin
               if (cnt != '0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  ready <= 1'b1;
                  err   <= bad;
                  rdata <= (bad || l_we) ? '0 : ldata;
                  state <= RESP;
               end
            end
            RESP: begin
               ready <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               ready <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised bench for dmem_responder against a byte-array memory model, plus
// directed latency, lane, extension, error, reset and back-to-back cases.
module tb_dmem_responder;

   localparam int AW   = 10;
   localparam int WC   = 2;
   localparam int MEMB = 128;

   logic        clk = 1'b0;
   logic        reset;
   logic        req, we, uns;
   logic [1:0]  size;
   logic [31:0] addr, wdata;
   logic        busy, ready, err;
   logic [31:0] rdata;

   logic        req0, we0, uns0;
   logic [1:0]  size0;
   logic [31:0] addr0, wdata0;
   logic        busy0, ready0, err0;
   logic [31:0] rdata0;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem_b [MEMB];

   always #5 clk = ~clk;

   dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .size(size),
      .uns(uns), .wdata(wdata), .busy(busy), .ready(ready), .err(err), .rdata(rdata)
   );

   dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .size(size0),
      .uns(uns0), .wdata(wdata0), .busy(busy0), .ready(ready0), .err(err0), .rdata(rdata0)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference: little-endian byte memory, rules applied directly to the request
   task automatic model(input logic w, input logic [31:0] a, input logic [1:0] s,
                        input logic u, input logic [31:0] wd,
                        output logic e, output logic [31:0] rd);
      int nb;
      logic [31:0] v;
      nb = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
      e  = (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'b00)
           || (a >= (32'd1 << (AW + 2)));
      rd = '0;
      if (!e) begin
         if (w) begin
            for (int i = 0; i < nb; i++)
               mem_b[(int'(a) + i) % MEMB] = wd[8*i +: 8];
         end else begin
            v = '0;
            for (int i = 0; i < nb; i++)
               v[8*i +: 8] = mem_b[(int'(a) + i) % MEMB];
            if (!u && nb == 1)
               v = {{24{v[7]}}, v[7:0]};
            else if (!u && nb == 2)
               v = {{16{v[15]}}, v[15:0]};
            rd = v;
         end
      end
   endtask

   task automatic do_req(input string tag, input logic w, input logic [31:0] a,
                         input logic [1:0] s, input logic u, input logic [31:0] wd,
                         output logic [31:0] got);
      logic        e_exp;
      logic [31:0] rd_exp;
      int          n;
      model(w, a, s, u, wd, e_exp, rd_exp);
      req = 1'b1; we = w; addr = a; size = s; uns = u; wdata = wd;
      tick;
      req = 1'b0; we = ~w; addr = $urandom; size = 2'($urandom); uns = ~u; wdata = $urandom;
      n = 1;
      while (!ready && n < 50) begin
         chk({tag, "_busy_wait"}, busy, 1'b1);
         tick;
         n++;
      end
      chk({tag, "_latency"}, n, WC + 2);
      chk({tag, "_busy_resp"}, busy, 1'b1);
      chk({tag, "_err"}, err, e_exp);
      chk({tag, "_rdata"}, rdata, rd_exp);
      got = rdata;
      tick;
      chk({tag, "_ready_drop"}, ready, 1'b0);
      chk({tag, "_busy_drop"}, busy, 1'b0);
      chk({tag, "_err_hold"}, err, e_exp);
      chk({tag, "_rdata_hold"}, rdata, rd_exp);
   endtask

   initial begin
      logic [31:0] got, a, wd;
      logic [1:0]  s;
      logic        w, u;

      reset = 1'b0; req = 1'b0; we = 1'b0; addr = '0; size = '0; uns = 1'b0; wdata = '0;
      req0 = 1'b0; we0 = 1'b0; addr0 = '0; size0 = '0; uns0 = 1'b0; wdata0 = '0;
      tick; tick;
      chk("rst_busy", busy, 1'b0);
      chk("rst_ready", ready, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_rdata", rdata, 32'h0);
      reset = 1'b1;
      tick;

      for (int i = 0; i < MEMB / 4; i++)
         do_req("preload", 1'b1, 32'(4 * i), 2'd2, 1'b0, $urandom, got);

      // reset in the middle of WAIT abandons the store
      req = 1'b1; we = 1'b1; addr = 32'h10; size = 2'd2; uns = 1'b0; wdata = 32'hDEADBEEF;
      tick;
      req = 1'b0;
      tick;
      reset = 1'b0;
      tick;
      reset = 1'b1;
      chk("midwait_busy", busy, 1'b0);
      chk("midwait_ready", ready, 1'b0);
      chk("midwait_rdata", rdata, 32'h0);
      chk("midwait_err", err, 1'b0);
      for (int i = 0; i < 6; i++) begin
         chk("midwait_noready", ready, 1'b0);
         tick;
      end
      do_req("midwait_ld", 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, got);

      // reset on the access edge suppresses the write
      req = 1'b1; we = 1'b1; addr = 32'h14; size = 2'd2; uns = 1'b0; wdata = 32'hCAFEF00D;
      tick;
      req = 1'b0;
      for (int i = 0; i < WC; i++) tick;
      reset = 1'b0;
      tick;
      reset = 1'b1;
      chk("accrst_ready", ready, 1'b0);
      chk("accrst_busy", busy, 1'b0);
      tick;
      chk("accrst_noready", ready, 1'b0);
      do_req("accrst_ld", 1'b0, 32'h14, 2'd2, 1'b0, 32'h0, got);

      do_req("lat_st", 1'b1, 32'h20, 2'd2, 1'b0, 32'h12345678, got);
      do_req("lat_ld", 1'b0, 32'h20, 2'd2, 1'b0, 32'h0, got);

      do_req("lane_sw", 1'b1, 32'h40, 2'd2, 1'b0, 32'h11223344, got);
      do_req("lane_sb", 1'b1, 32'h41, 2'd0, 1'b0, 32'h000000AA, got);
      do_req("lane_sh", 1'b1, 32'h42, 2'd1, 1'b0, 32'h0000BEEF, got);
      do_req("lane_lw", 1'b0, 32'h40, 2'd2, 1'b0, 32'h0, got);
      chk("lane_word", got, 32'hBEEFAA44);
      do_req("lb", 1'b0, 32'h41, 2'd0, 1'b0, 32'h0, got);
      chk("lb_val", got, 32'hFFFFFFAA);
      do_req("lbu", 1'b0, 32'h41, 2'd0, 1'b1, 32'h0, got);
      chk("lbu_val", got, 32'h000000AA);
      do_req("lh", 1'b0, 32'h42, 2'd1, 1'b0, 32'h0, got);
      chk("lh_val", got, 32'hFFFFBEEF);
      do_req("lhu", 1'b0, 32'h42, 2'd1, 1'b1, 32'h0, got);
      chk("lhu_val", got, 32'h0000BEEF);

      do_req("err_lw22", 1'b0, 32'h22, 2'd2, 1'b0, 32'h0, got);
      do_req("err_sh21", 1'b1, 32'h21, 2'd1, 1'b0, 32'h5555, got);
      do_req("err_sz3", 1'b1, 32'h20, 2'd3, 1'b0, 32'hFFFFFFFF, got);
      do_req("err_oor", 1'b1, 32'(1) << (AW + 2), 2'd2, 1'b0, 32'hA5A5A5A5, got);
      do_req("err_lw20", 1'b0, 32'h20, 2'd2, 1'b0, 32'h0, got);
      do_req("err_lw00", 1'b0, 32'h0, 2'd2, 1'b0, 32'h0, got);

      for (int i = 0; i < 300; i++) begin
         w = 1'($urandom);
         u = 1'($urandom);
         wd = $urandom;
         s = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         if ($urandom_range(0, 9) == 0)
            a = ($urandom_range(0, 1) == 0) ? (32'h1000 | 32'($urandom_range(0, 127))) : ($urandom | 32'h8000_0000);
         else
            a = 32'($urandom_range(0, MEMB - 1));
         if ($urandom_range(0, 3) != 0 && s == 2'd1) a[0] = 1'b0;
         if ($urandom_range(0, 3) != 0 && s == 2'd2) a[1:0] = 2'b00;
         do_req("rand", w, a, s, u, wd, got);
      end

      for (int i = 0; i < MEMB / 4; i++)
         do_req("sweep", 1'b0, 32'(4 * i), 2'd2, 1'b0, 32'h0, got);

      // zero-wait instance with req held high: one acceptance every 3 cycles
      req0 = 1'b1; we0 = 1'b1; addr0 = 32'h8; size0 = 2'd2; uns0 = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         wdata0 = $urandom;
         tick;
         chk("b2b_ready", ready0, (k >= 2) && ((k - 2) % 3 == 0));
         chk("b2b_busy", busy0, (k % 3) != 0);
         if ((k >= 2) && ((k - 2) % 3 == 0)) begin
            chk("b2b_err", err0, 1'b0);
            chk("b2b_rdata", rdata0, 32'h0);
         end
      end
      req0 = 1'b0;
      tick; tick;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
